freq_meter: RTL

- Measures the period of a slow external square wave (e.g. a divided clock or a sensor pulse train) in units of the system clock `clk`.
- It is the receiving end of a clock-division path: a divider produces a slow toggle, and this block recovers the slow signal's period as a number.
- It sits on the `clk` domain next to the divider logic.
- It returns the result over a single-cycle valid pulse to the control/display logic.

---
 rtl/freq_meter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: measures the period of a slow, asynchronous square wave in clk cycles.
//   Ports: clk, rst (sync, active-high); start requests one measurement (taken in IDLE only);
//   sig_in is the asynchronous signal; busy is high during ARM/MEASURE/DONE;
//   period holds the last result; valid and timeout are one-cycle pulses.
//   Build option FREQ_METER_AVG_EN: average four back-to-back periods into one result.
module freq_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  // Last counter value a phase may reach before it gives up.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   rise;

  // Synchronizer chain followed by a one-cycle history register for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise    = sync[SYNC_STAGES-1] & ~prev;
  // Safe from overflow: the timeout limit stops cnt at TIMEOUT-1 <= 2^CNT_W-2.
  assign cnt_inc = cnt + CNT_W'(1);

`ifdef FREQ_METER_AVG_EN
  logic [CNT_W+1:0] acc;
  logic [1:0]       idx;
  logic [CNT_W+1:0] acc_sum;

  // Running sum including the period that the current rise is closing.
  assign acc_sum = acc + {2'b00, cnt_inc};
`endif

  // The result is written straight into period when MEASURE ends, so period and
  // valid both become visible in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      acc     <= '0;
      idx     <= '0;
`endif
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= '0;
`ifdef FREQ_METER_AVG_EN
            acc   <= '0;
            idx   <= '0;
`endif
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        MEASURE: begin
          // A rise on the final counting cycle still completes the period.
          if (rise) begin
`ifdef FREQ_METER_AVG_EN
            if (idx == 2'd3) begin
              period <= CNT_W'(acc_sum >> 2);
              valid  <= 1'b1;
              state  <= DONE;
            end else begin
              acc <= acc_sum;
              idx <= idx + 2'd1;
              cnt <= '0;
            end
`else
            period <= cnt_inc;
            valid  <= 1'b1;
            state  <= DONE;
`endif
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
